// File: rtl/dff_shift_ctrl.sv
// Start/ready sequencer for a WIDTH-bit D flip-flop chain: parallel load, MSB-first serial shift,
// serial capture into rx_data, plus idle-time clear/preset of the chain.
module dff_shift_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             Rd,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ser_in,
  input  logic             abort,
  input  logic             clr_cmd,
  input  logic             set_cmd,
  output logic             ready,
  output logic             busy,
  output logic             shift_en,
  output logic             ser_out,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] chain_q
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] chain_d;
  logic [WIDTH-1:0] rx_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {chain_q[WIDTH-2:0], ser_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    rx_d    = rx_data;
    case (state_q)
      IDLE: begin
        // Commands win over start; a start that loses is dropped, not remembered.
        if (clr_cmd) begin
          chain_d = '0;
        end else if (set_cmd) begin
          chain_d = '1;
        end else if (start) begin
          chain_d = tx_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          chain_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          chain_d = shifted;
          if (cnt_q == CntLast) begin
            rx_d    = shifted;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rd) begin
    if (!Rd) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chain_q <= '0;
      rx_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      rx_data <= rx_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == SHIFT);
  assign shift_en = busy;
  assign done     = (state_q == DONE);
  assign ser_out  = busy & chain_q[WIDTH-1];

endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Scoreboard bench for dff_shift_ctrl: expected serial bits and received words are queued by the
// stimulus and checked by a monitor whenever the DUT shifts or pulses done.
module tb_dff_shift_ctrl;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rd;
  logic             start, ser_in_drv, ser_in, abort, clr_cmd, set_cmd, loop;
  logic [WIDTH-1:0] tx_data;
  logic             ready, busy, shift_en, ser_out, done;
  logic [WIDTH-1:0] rx_data, chain_q;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_rx_q[$];
  logic             exp_ser_q[$];

  always #5 clk = ~clk;

  assign ser_in = loop ? ser_out : ser_in_drv;

  dff_shift_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .Rd       (rd),
    .start    (start),
    .tx_data  (tx_data),
    .ser_in   (ser_in),
    .abort    (abort),
    .clr_cmd  (clr_cmd),
    .set_cmd  (set_cmd),
    .ready    (ready),
    .busy     (busy),
    .shift_en (shift_en),
    .ser_out  (ser_out),
    .done     (done),
    .rx_data  (rx_data),
    .chain_q  (chain_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] ser_bits);
    for (int k = WIDTH - 1; k >= 0; k--) exp_ser_q.push_back(ser_bits[k]);
    exp_rx_q.push_back(w);
  endtask

  // Monitor: sample away from the active edge, only while out of reset.
  always @(negedge clk) begin
    if (rd === 1'b1) begin
      if (busy) begin
        if (exp_ser_q.size() == 0) chk("ser_out_unexpected_shift", 32'd1, 32'd0);
        else chk("ser_out", ser_out, exp_ser_q.pop_front());
        chk("shift_en_eq_busy", shift_en, busy);
      end
      if (done) begin
        if (exp_rx_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] bb_words [3];
    logic [WIDTH-1:0] cc_bits;
    bb_words[0] = 8'h81;
    bb_words[1] = 8'h7E;
    bb_words[2] = 8'h55;
    cc_bits = 8'hCC;

    rd = 1'b0; start = 1'b0; ser_in_drv = 1'b0; abort = 1'b0;
    clr_cmd = 1'b0; set_cmd = 1'b0; loop = 1'b0; tx_data = '0;
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_chain", chain_q, 0);
    tick();
    rd = 1'b1;
    tick();

    // Loopback A5: done in the 9th cycle after accept, ready in the 10th.
    loop = 1'b1;
    push_word(8'hA5, 8'hA5);
    tx_data = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("a5_busy_after_accept", busy, 1);
    chk("a5_ready_low", ready, 0);
    repeat (WIDTH) tick();
    chk("a5_done_timing", done, 1);
    chk("a5_ready_in_done", ready, 0);
    tick();
    chk("a5_ready_back", ready, 1);
    chk("a5_done_one_cycle", done, 0);
    chk("a5_chain_holds_rx", chain_q, 8'hA5);

    // tx 00 with driven serial input 1,1,0,0,1,1,0,0.
    loop = 1'b0;
    push_word(8'hCC, 8'h00);
    tx_data = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      ser_in_drv = cc_bits[k];
      tick();
    end
    ser_in_drv = 1'b0;
    chk("cc_done", done, 1);
    tick();
    chk("cc_chain_holds_rx", chain_q, 8'hCC);

    // Abort in the 4th shift cycle.
    for (int k = 0; k < 4; k++) exp_ser_q.push_back(1'b1);
    tx_data = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort4_ready", ready, 1);
    chk("abort4_chain", chain_q, 0);
    chk("abort4_rx_kept", rx_data, 8'hCC);
    tick();
    chk("abort4_no_done", done, 0);

    // Abort coincident with the last shift cycle.
    for (int k = 0; k < WIDTH; k++) exp_ser_q.push_back(1'b1);
    tx_data = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (WIDTH - 1) tick();
    chk("abort_last_still_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_last_no_done", done, 0);
    chk("abort_last_ready", ready, 1);
    chk("abort_last_rx_kept", rx_data, 8'hCC);
    tick();
    chk("abort_last_no_done_later", done, 0);

    // Idle commands.
    set_cmd = 1'b1;
    tick();
    set_cmd = 1'b0;
    chk("set_cmd_chain", chain_q, 8'hFF);
    clr_cmd = 1'b1; set_cmd = 1'b1;
    tick();
    clr_cmd = 1'b0; set_cmd = 1'b0;
    chk("clr_beats_set", chain_q, 8'h00);
    set_cmd = 1'b1;
    tick();
    set_cmd = 1'b0;
    tx_data = 8'h5A; start = 1'b1; clr_cmd = 1'b1;
    tick();
    start = 1'b0; clr_cmd = 1'b0;
    chk("start_clr_stays_idle", ready, 1);
    chk("start_clr_chain", chain_q, 8'h00);
    tick();
    chk("start_clr_not_queued", busy, 0);

    // clr_cmd and start during SHIFT are ignored.
    loop = 1'b1;
    push_word(8'h96, 8'h96);
    tx_data = 8'h96; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clr_cmd = 1'b1; start = 1'b1; tx_data = 8'h00;
    tick();
    clr_cmd = 1'b0; start = 1'b0;
    repeat (WIDTH - 3) tick();
    chk("shift_cmds_ignored_done", done, 1);
    tick();
    chk("shift_cmds_ignored_chain", chain_q, 8'h96);

    // Asynchronous reset mid-shift, cycle 5.
    for (int k = 0; k < 5; k++) exp_ser_q.push_back(k < 4);
    tx_data = 8'hF0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rd = 1'b0;
    #1;
    chk("async_rst_ready", ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ser_out", ser_out, 0);
    chk("async_rst_chain", chain_q, 0);
    chk("async_rst_rx", rx_data, 0);
    chk("async_rst_done", done, 0);
    tick();
    rd = 1'b1;
    tick();
    chk("post_rst_idle", ready, 1);
    push_word(8'h3C, 8'h3C);
    tx_data = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (WIDTH) tick();
    chk("post_rst_done", done, 1);
    tick();

    // Back-to-back with start held: one accept every WIDTH+2 cycles.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(bb_words[i], bb_words[i]);
      tx_data = bb_words[i];
      chk("b2b_ready_before_accept", ready, 1);
      tick();
      chk("b2b_busy_after_accept", busy, 1);
      tx_data = 8'h00;
      repeat (WIDTH - 1) tick();
      chk("b2b_busy_last_cycle", busy, 1);
      tick();
      chk("b2b_done", done, 1);
      chk("b2b_not_ready_in_done", ready, 0);
      tick();
      chk("b2b_idle_after_done", busy, 0);
    end
    start = 1'b0;
    loop = 1'b0;
    tick();
    tick();
    chk("scoreboard_rx_drained", exp_rx_q.size(), 0);
    chk("scoreboard_ser_drained", exp_ser_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_shift_ctrl.md
Name: dff_shift_ctrl

Overview:
- Sequencer for a WIDTH-bit chain of D flip-flops used as a parallel-in/serial-out and serial-in/parallel-out shift register.
- Accepts a parallel word on a start/ready handshake and shifts it out MSB-first, one bit per clock.
- Captures WIDTH serial input bits into rx_data and pulses done.
- Also provides synchronous clear/preset commands for the chain while idle, mirroring the flip-flop's reset/set controls at the register level.

Parameters:
- WIDTH, default 8: shift chain length in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- Rd  input  1  asynchronous active-low reset.
- start  input  1  request to begin a transfer; accepted only when ready=1.
- tx_data  input  WIDTH  parallel word captured on an accepted start.
- ser_in  input  1  serial input bit, sampled every SHIFT cycle.
- abort  input  1  cancels an in-progress transfer.
- clr_cmd  input  1  synchronous clear of the chain (honoured in IDLE only).
- set_cmd  input  1  synchronous preset of the chain to all ones (honoured in IDLE only).
- ready  output  1  high in IDLE.
- busy  output  1  high in SHIFT.
- shift_en  output  1  shift strobe for downstream flops; equals busy.
- ser_out  output  1  current MSB of the chain during SHIFT; 0 otherwise.
- done  output  1  one-cycle pulse when rx_data is updated.
- rx_data  output  WIDTH  last completed received word.
- chain_q  output  WIDTH  current chain contents.

Behaviour:
- Reset: Rd low forces, asynchronously:
  - state=IDLE, chain=0, cnt=0, rx_data=0;
  - ready=1, busy=0, shift_en=0, done=0, ser_out=0.
  - Reset mid-transfer discards the transfer; no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state/chain only. No input-to-output combinational path.
- IDLE, evaluated each edge, priority clr_cmd > set_cmd > start:
  - clr_cmd: chain<=0.
  - set_cmd: chain<={WIDTH{1}}.
  - start (with neither command): chain<=tx_data, cnt<=0, go to SHIFT.
  - A start coincident with clr_cmd or set_cmd is dropped, not queued.
- SHIFT:
  - ser_out=chain[WIDTH-1].
  - Each edge: chain<={chain[WIDTH-2:0],ser_in}, cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE and rx_data<={chain[WIDTH-2:0],ser_in}.
  - k-th SHIFT cycle (k=0..WIDTH-1): ser_out=tx_data[WIDTH-1-k]. ser_in sampled that cycle lands in rx_data[WIDTH-1-k].
- DONE: done=1 for exactly one cycle, ready=0; then IDLE unconditionally.
- Latency: start accepted at edge E. SHIFT occupies the WIDTH cycles after E. done is high in cycle E+WIDTH+1. ready returns at E+WIDTH+2.
- abort:
  - In SHIFT: go to IDLE next edge, chain<=0, cnt<=0, rx_data unchanged, no done. abort beats the final-bit transition on the same edge.
  - In IDLE/DONE: ignored.
- start, clr_cmd, set_cmd asserted during SHIFT or DONE: ignored, not queued.
- cnt width ceil(log2(WIDTH)); saturates by state exit and never wraps inside SHIFT.
- chain_q reflects the chain continuously. After a completed transfer the chain holds rx_data until the next command or start.

Test Plan:
- Reset, then WIDTH=8, tx_data=8'hA5, ser_in tied to ser_out (loopback), start one cycle:
  - ser_out sequence 1,0,1,0,0,1,0,1 over 8 busy cycles;
  - done pulses one cycle at E+9; rx_data=8'hA5; ready high at E+10.
- tx_data=8'h00, ser_in driven 1,1,0,0,1,1,0,0:
  - rx_data=8'hCC; ser_out stays 0 throughout.
- Abort during SHIFT:
  - Start with 8'hFF, assert abort in the 4th SHIFT cycle → IDLE next edge; done never asserts; rx_data retains its prior value; chain_q=0.
  - Repeat with abort coincident with the last SHIFT cycle → no done.
- Commands in IDLE:
  - set_cmd → chain_q=8'hFF.
  - clr_cmd+set_cmd together → chain_q=8'h00.
  - start+clr_cmd together → stays IDLE, chain_q=0.
  - clr_cmd and start during SHIFT → ignored; transfer completes normally.
- Rd pulsed low mid-SHIFT (cycle 5), asynchronously between clock edges → all outputs at reset values immediately; no done. A fresh start after release transfers 8'h3C correctly.
- Back-to-back transfers: start held high continuously → accepted only in IDLE cycles, i.e. one accept per WIDTH+2 cycles; each done pulse matches its word.
